// File: rtl/bcd_cred_if.sv
// Button/digit inputs and status outputs of the BCD credential checker, with debug taps
// for the FSM state and the failed-attempt counter.
interface bcd_cred_if #(
  parameter int UIDX_W = 2
);
  // Press semantics: load and logout are active-low levels. One press is the single cycle
  // in which the registered previous level is 1 and the current level is 0. Holding low adds
  // nothing. digit_in is sampled in that press cycle only.
  logic              load;
  logic              logout;
  logic [3:0]        digit_in;
  logic              logged_in;
  logic              logged_out;
  logic              is_guest;
  logic [UIDX_W-1:0] user_idx;
  logic [3:0]        digit_cnt;
  logic [3:0]        last_digit;
  logic              locked;
  logic              err;
  logic [2:0]        state_dbg;
  logic [3:0]        fail_cnt_dbg;

  modport master (
    output load, logout, digit_in,
    input  logged_in, logged_out, is_guest, user_idx, digit_cnt, last_digit,
           locked, err, state_dbg, fail_cnt_dbg
  );

  modport slave (
    input  load, logout, digit_in,
    output logged_in, logged_out, is_guest, user_idx, digit_cnt, last_digit,
           locked, err, state_dbg, fail_cnt_dbg
  );
endinterface

// File: rtl/bcd_credential_checker.sv
// Login front end: collects an ID then a password as BCD digits and matches them against a table.
// Optional inactivity timeout is enabled by defining BCD_CRED_TIMEOUT_EN.
module bcd_credential_checker #(
  parameter int ID_DIGITS = 4,
  parameter int PW_DIGITS = 6,
  parameter int NUM_USERS = 4,
  parameter int UIDX_W    = 2,
  parameter logic [NUM_USERS*ID_DIGITS*4-1:0] ID_TABLE = 64'h0000_1111_2222_1234,
  parameter logic [NUM_USERS*PW_DIGITS*4-1:0] PW_TABLE = 96'h000000_111111_222222_012345,
  parameter int MAX_TRIES      = 3,
  parameter int LOCK_CYCLES    = 100,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  bcd_cred_if.slave  bus
);

  localparam int ID_W = ID_DIGITS * 4;
  localparam int PW_W = PW_DIGITS * 4;
  localparam int LCW  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic [2:0] {
    ID_ENTRY  = 3'd0,
    CHECK_ID  = 3'd1,
    PW_ENTRY  = 3'd2,
    CHECK_PW  = 3'd3,
    LOCKOUT   = 3'd4,
    LOGGED_IN = 3'd5
  } state_t;

  state_t            state, state_d;
  logic              load_q, logout_q;
  logic              load_press, logout_press, digit_ok;
  logic [ID_W-1:0]   id_reg;
  logic [PW_W-1:0]   pw_reg;
  logic [3:0]        digit_cnt, last_digit, fail_cnt;
  logic [UIDX_W-1:0] user_idx, hit_idx;
  logic              is_guest, err;
  logic              id_guest, id_hit, pw_hit, out_of_tries, lock_done, timeout;
  logic [LCW-1:0]    lock_cnt;

  assign load_press   = load_q & ~bus.load;
  assign logout_press = logout_q & ~bus.logout;
  assign digit_ok     = (bus.digit_in <= 4'd9);
  assign id_guest     = (id_reg == {ID_DIGITS{4'h9}});
  assign out_of_tries = ((fail_cnt + 4'd1) >= 4'(MAX_TRIES));
  assign lock_done    = (lock_cnt == LCW'(LOCK_CYCLES - 1));

  // Scan downwards so the lowest matching index is the one left in hit_idx.
  always_comb begin
    id_hit  = 1'b0;
    hit_idx = '0;
    pw_hit  = 1'b0;
    for (int k = NUM_USERS - 1; k >= 0; k--) begin
      if (id_reg == ID_TABLE[k*ID_W +: ID_W]) begin
        id_hit  = 1'b1;
        hit_idx = UIDX_W'(k);
      end
    end
    for (int k = 0; k < NUM_USERS; k++) begin
      if (user_idx == UIDX_W'(k) && pw_reg == PW_TABLE[k*PW_W +: PW_W]) pw_hit = 1'b1;
    end
  end

`ifdef BCD_CRED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;
  logic          entry_busy;

  assign entry_busy = (state == ID_ENTRY || state == PW_ENTRY) && (digit_cnt != 4'd0);
  assign timeout    = entry_busy && !load_press && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                  idle_cnt <= '0;
    else if (!entry_busy || load_press || timeout) idle_cnt <= '0;
    else                                         idle_cnt <= idle_cnt + 1'b1;
  end
`else
  // No idle timer in this build; partial entries wait indefinitely.
  assign timeout = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ID_ENTRY;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ID_ENTRY: begin
        if (!timeout && load_press && digit_ok && digit_cnt == 4'(ID_DIGITS - 1))
          state_d = CHECK_ID;
      end
      CHECK_ID: begin
        if (id_guest)          state_d = LOGGED_IN;
        else if (id_hit)       state_d = PW_ENTRY;
        else if (out_of_tries) state_d = LOCKOUT;
        else                   state_d = ID_ENTRY;
      end
      PW_ENTRY: begin
        if (timeout)
          state_d = ID_ENTRY;
        else if (load_press && digit_ok && digit_cnt == 4'(PW_DIGITS - 1))
          state_d = CHECK_PW;
      end
      CHECK_PW: begin
        if (pw_hit)            state_d = LOGGED_IN;
        else if (out_of_tries) state_d = LOCKOUT;
        else                   state_d = ID_ENTRY;
      end
      LOCKOUT:   if (lock_done)    state_d = ID_ENTRY;
      LOGGED_IN: if (logout_press) state_d = ID_ENTRY;
      default:   state_d = ID_ENTRY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_q     <= 1'b1;
      logout_q   <= 1'b1;
      id_reg     <= '0;
      pw_reg     <= '0;
      digit_cnt  <= 4'd0;
      last_digit <= 4'd0;
      fail_cnt   <= 4'd0;
      user_idx   <= '0;
      is_guest   <= 1'b0;
      err        <= 1'b0;
      lock_cnt   <= '0;
    end else begin
      load_q   <= bus.load;
      logout_q <= bus.logout;
      err      <= 1'b0;
      case (state)
        ID_ENTRY, PW_ENTRY: begin
          if (timeout) begin
            err       <= 1'b1;
            id_reg    <= '0;
            pw_reg    <= '0;
            digit_cnt <= 4'd0;
            user_idx  <= '0;
          end else if (load_press) begin
            if (!digit_ok) begin
              err <= 1'b1;
            end else begin
              if (state == ID_ENTRY) id_reg <= (id_reg << 4) | ID_W'(bus.digit_in);
              else                   pw_reg <= (pw_reg << 4) | PW_W'(bus.digit_in);
              last_digit <= bus.digit_in;
              digit_cnt  <= digit_cnt + 4'd1;
            end
          end
        end
        CHECK_ID: begin
          digit_cnt <= 4'd0;
          id_reg    <= '0;
          if (id_guest) begin
            is_guest <= 1'b1;
            user_idx <= '0;
            fail_cnt <= 4'd0;
          end else if (id_hit) begin
            user_idx <= hit_idx;
          end else begin
            err      <= 1'b1;
            fail_cnt <= fail_cnt + 4'd1;
          end
        end
        CHECK_PW: begin
          digit_cnt <= 4'd0;
          id_reg    <= '0;
          pw_reg    <= '0;
          if (pw_hit) begin
            fail_cnt <= 4'd0;
          end else begin
            err      <= 1'b1;
            fail_cnt <= fail_cnt + 4'd1;
            user_idx <= '0;
          end
        end
        LOCKOUT: begin
          if (lock_done) begin
            lock_cnt <= '0;
            fail_cnt <= 4'd0;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        LOGGED_IN: begin
          if (logout_press) begin
            is_guest  <= 1'b0;
            user_idx  <= '0;
            digit_cnt <= 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.logged_in    = (state == LOGGED_IN);
  assign bus.logged_out   = (state != LOGGED_IN);
  assign bus.locked       = (state == LOCKOUT);
  assign bus.is_guest     = is_guest;
  assign bus.user_idx     = user_idx;
  assign bus.digit_cnt    = digit_cnt;
  assign bus.last_digit   = last_digit;
  assign bus.err          = err;
  assign bus.state_dbg    = state;
  assign bus.fail_cnt_dbg = fail_cnt;

endmodule

// File: tb/tb_bcd_credential_checker.sv
// Directed bench for bcd_credential_checker: guest and user logins, failed checks, lockout,
// invalid digits, held buttons, reset mid-entry and the idle behaviour of the current build.
module tb_bcd_credential_checker;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  logic [3:0] exp_q[$];

  bcd_cred_if #(.UIDX_W(2)) bus ();

  bcd_credential_checker #(
    .ID_DIGITS(4), .PW_DIGITS(6), .NUM_USERS(4), .UIDX_W(2),
    .ID_TABLE(64'h0000_1111_2222_1234),
    .PW_TABLE(96'h000000_111111_222222_012345),
    .MAX_TRIES(3), .LOCK_CYCLES(100), .TIMEOUT_CYCLES(20)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000 ns");
    $fatal(1);
  end

  // Checker
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_load(input logic [3:0] d);
    @(posedge clk); #1;
    bus.digit_in = d;
    bus.load     = 1'b0;
    @(posedge clk); #1;
    bus.load     = 1'b1;
  endtask

  task automatic press_logout();
    @(posedge clk); #1;
    bus.logout = 1'b0;
    @(posedge clk); #1;
    bus.logout = 1'b1;
  endtask

  // Enter n digits MSD first; each accepted digit must show up on last_digit.
  task automatic enter_field(input logic [31:0] digs, input int n);
    logic [3:0] d;
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(digs[i*4 +: 4]);
    while (exp_q.size() > 0) begin
      d = exp_q.pop_front();
      press_load(d);
      chk("last_digit", {28'd0, bus.last_digit}, {28'd0, d});
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    bus.load     = 1'b1;
    bus.logout   = 1'b1;
    bus.digit_in = 4'd0;
    reset        = 1'b1;
    #1;
    apply_reset();

    // Reset state
    chk("rst_logged_out", {31'd0, bus.logged_out}, 32'd1);
    chk("rst_logged_in",  {31'd0, bus.logged_in},  32'd0);
    chk("rst_digit_cnt",  {28'd0, bus.digit_cnt},  32'd0);
    chk("rst_err",        {31'd0, bus.err},        32'd0);
    chk("rst_locked",     {31'd0, bus.locked},     32'd0);
    chk("rst_state",      {29'd0, bus.state_dbg},  32'd0);

    // Guest login with 9999
    enter_field(32'h9999, 4);
    chk("guest_chk_state", {29'd0, bus.state_dbg}, 32'd1);
    step(1);
    chk("guest_logged_in",  {31'd0, bus.logged_in},  32'd1);
    chk("guest_is_guest",   {31'd0, bus.is_guest},   32'd1);
    chk("guest_logged_out", {31'd0, bus.logged_out}, 32'd0);
    press_load(4'd3);
    chk("guest_load_ignored_cnt",  {28'd0, bus.digit_cnt},  32'd0);
    chk("guest_load_ignored_last", {28'd0, bus.last_digit}, 32'd9);
    press_logout();
    chk("guest_logout_out",   {31'd0, bus.logged_out}, 32'd1);
    chk("guest_logout_guest", {31'd0, bus.is_guest},   32'd0);

    // User 0: ID 1234, password 012345
    enter_field(32'h1234, 4);
    step(1);
    chk("u0_pw_state", {29'd0, bus.state_dbg}, 32'd2);
    chk("u0_pw_cnt",   {28'd0, bus.digit_cnt}, 32'd0);
    enter_field(32'h012345, 6);
    step(1);
    chk("u0_logged_in", {31'd0, bus.logged_in}, 32'd1);
    chk("u0_user_idx",  {30'd0, bus.user_idx},  32'd0);
    chk("u0_is_guest",  {31'd0, bus.is_guest},  32'd0);

    // Load and logout in the same cycle: logout wins
    @(posedge clk); #1;
    bus.digit_in = 4'd7;
    bus.load     = 1'b0;
    bus.logout   = 1'b0;
    @(posedge clk); #1;
    bus.load     = 1'b1;
    bus.logout   = 1'b1;
    chk("both_logged_in", {31'd0, bus.logged_in},  32'd0);
    chk("both_digit_cnt", {28'd0, bus.digit_cnt},  32'd0);
    chk("both_last",      {28'd0, bus.last_digit}, 32'd5);

    // Wrong password for user 0
    enter_field(32'h1234, 4);
    step(1);
    enter_field(32'h012346, 6);
    step(1);
    chk("badpw_err",       {31'd0, bus.err},          32'd1);
    chk("badpw_state",     {29'd0, bus.state_dbg},    32'd0);
    chk("badpw_fail_cnt",  {28'd0, bus.fail_cnt_dbg}, 32'd1);
    chk("badpw_logged_in", {31'd0, bus.logged_in},    32'd0);
    step(1);
    chk("badpw_err_pulse", {31'd0, bus.err}, 32'd0);

    // User 3: ID 0000 / 000000, clears the fail count
    enter_field(32'h0000, 4);
    step(1);
    enter_field(32'h000000, 6);
    step(1);
    chk("u3_logged_in", {31'd0, bus.logged_in},    32'd1);
    chk("u3_user_idx",  {30'd0, bus.user_idx},     32'd3);
    chk("u3_fail_cnt",  {28'd0, bus.fail_cnt_dbg}, 32'd0);
    press_logout();
    chk("u3_logout_idx", {30'd0, bus.user_idx}, 32'd0);

    // Invalid digit, then a held load button
    press_load(4'hC);
    chk("bad_digit_err", {31'd0, bus.err},       32'd1);
    chk("bad_digit_cnt", {28'd0, bus.digit_cnt}, 32'd0);
    step(1);
    chk("bad_digit_err_pulse", {31'd0, bus.err}, 32'd0);
    @(posedge clk); #1;
    bus.digit_in = 4'd2;
    bus.load     = 1'b0;
    step(5);
    bus.load     = 1'b1;
    chk("hold_cnt",  {28'd0, bus.digit_cnt},  32'd1);
    chk("hold_last", {28'd0, bus.last_digit}, 32'd2);
    enter_field(32'h222, 3);
    step(1);
    chk("u1_pw_state", {29'd0, bus.state_dbg}, 32'd2);
    chk("u1_user_idx", {30'd0, bus.user_idx},  32'd1);
    press_load(4'hF);
    chk("pw_bad_digit_err", {31'd0, bus.err},       32'd1);
    chk("pw_bad_digit_cnt", {28'd0, bus.digit_cnt}, 32'd0);
    enter_field(32'h22, 2);
    chk("pw_partial_cnt", {28'd0, bus.digit_cnt}, 32'd2);

    // Reset mid-entry takes effect without a clock edge
    reset = 1'b0;
    #1;
    chk("midrst_cnt",   {28'd0, bus.digit_cnt}, 32'd0);
    chk("midrst_state", {29'd0, bus.state_dbg}, 32'd0);
    chk("midrst_idx",   {30'd0, bus.user_idx},  32'd0);
    step(1);
    reset = 1'b1;

    // Three wrong IDs lead to lockout
    for (int t = 1; t <= 3; t++) begin
      enter_field(32'h5555, 4);
      step(1);
      chk("wrong_id_err",      {31'd0, bus.err},          32'd1);
      chk("wrong_id_fail_cnt", {28'd0, bus.fail_cnt_dbg}, t);
      chk("wrong_id_locked",   {31'd0, bus.locked},       (t == 3) ? 32'd1 : 32'd0);
    end
    press_load(4'd1);
    press_load(4'd2);
    press_load(4'd3);
    chk("lock_cnt_frozen", {28'd0, bus.digit_cnt}, 32'd0);
    chk("lock_mid",        {31'd0, bus.locked},    32'd1);
    step(93);
    chk("lock_last_cycle", {31'd0, bus.locked},    32'd1);
    step(1);
    chk("lock_released",   {31'd0, bus.locked},       32'd0);
    chk("lock_fail_clr",   {28'd0, bus.fail_cnt_dbg}, 32'd0);
    chk("lock_state",      {29'd0, bus.state_dbg},    32'd0);

    // Idle with a partial ID
    enter_field(32'h12, 2);
`ifdef BCD_CRED_TIMEOUT_EN
    step(19);
    chk("idle_before_err", {31'd0, bus.err},       32'd0);
    chk("idle_before_cnt", {28'd0, bus.digit_cnt}, 32'd2);
    step(1);
    chk("idle_err",      {31'd0, bus.err},          32'd1);
    chk("idle_cnt_clr",  {28'd0, bus.digit_cnt},    32'd0);
    chk("idle_fail_cnt", {28'd0, bus.fail_cnt_dbg}, 32'd0);
`else
    step(40);
    chk("idle_persist_cnt", {28'd0, bus.digit_cnt},    32'd2);
    chk("idle_no_err",      {31'd0, bus.err},          32'd0);
    chk("idle_fail_cnt",    {28'd0, bus.fail_cnt_dbg}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bcd_credential_checker.md
Name: bcd_credential_checker

Overview:
Parametrised login front end for the BCD math game family. It collects BCD digits one button press at a time, first an N-digit ID and then an M-digit password, and matches them against a table of NUM_USERS credentials. It supports a guest ID, counts failed attempts with a timed lockout, and drives login status and progress to the game core and the display decoders.

Parameters:
ID_DIGITS, 4, BCD digits per ID (1..8)
PW_DIGITS, 6, BCD digits per password (1..8)
NUM_USERS, 4, credential table entries (1..8)
UIDX_W, 2, width of user_idx; must satisfy 2**UIDX_W >= NUM_USERS
ID_TABLE, 64'h0000_1111_2222_1234, user k ID at bits [(k+1)*ID_DIGITS*4-1 : k*ID_DIGITS*4], MSD in the top nibble
PW_TABLE, 96'h000000_111111_222222_012345, user k password, same packing with PW_DIGITS
MAX_TRIES, 3, consecutive failed checks that trigger lockout
LOCK_CYCLES, 100, lockout duration in clk cycles
TIMEOUT_CYCLES, 1000, inactivity limit; used only with the optional feature

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
load  in  1  active-low digit-enter button, already synchronised
logout  in  1  active-low logout button, already synchronised
digit_in  in  4  BCD digit captured on a load press
logged_in  out  1  high while a session is active
logged_out  out  1  always the inverse of logged_in
is_guest  out  1  high while the session is a guest session
user_idx  out  UIDX_W  index of the matched user
digit_cnt  out  4  digits entered so far in the current field
last_digit  out  4  most recently accepted digit, for display
locked  out  1  high during lockout
err  out  1  one-cycle pulse on an invalid digit or a failed check

Behaviour:
- Reset values: state ID_ENTRY; logged_in, is_guest, locked, err, user_idx, digit_cnt, last_digit, fail_cnt = 0; logged_out = 1; load_q and logout_q = 1.
- Press detection: a press is the cycle where the registered previous value is 1 and the current input is 0. Exactly one press per falling edge; holding the button low adds nothing further.
- Digit handling: on a load press with digit_in > 9, pulse err, discard the digit, leave digit_cnt unchanged. A valid digit shifts into the active field register MSD-first, updates last_digit, and increments digit_cnt.
- ID_ENTRY: when digit_cnt reaches ID_DIGITS, go to CHECK_ID on the next cycle.
- CHECK_ID (one cycle; digit_cnt clears to 0):
  - ID all nines: go to LOGGED_IN with is_guest = 1.
  - ID matches user k: go to PW_ENTRY with user_idx = k. On duplicate IDs, the lowest k wins.
  - Otherwise: treat as a failed check.
- PW_ENTRY: when digit_cnt reaches PW_DIGITS, go to CHECK_PW.
- CHECK_PW: if the password equals PW_TABLE[user_idx], go to LOGGED_IN with is_guest = 0; otherwise treat as a failed check.
- Failed check: pulse err; fail_cnt += 1. If fail_cnt reaches MAX_TRIES, go to LOCKOUT; else return to ID_ENTRY. Field registers and digit_cnt clear.
- LOCKOUT: locked = 1; a counter runs LOCK_CYCLES cycles, then the block returns to ID_ENTRY with fail_cnt = 0 and locked = 0.
- LOGGED_IN: logged_in = 1 and fail_cnt clears on entry. A logout press returns to ID_ENTRY and clears is_guest, user_idx and digit_cnt.
- Outputs in the transition cycle: logged_in rises in the cycle after the last digit's CHECK cycle, so the final digit press to logged_in takes 2 cycles.
- Ignored inputs:
  - load presses in CHECK_ID, CHECK_PW, LOCKOUT and LOGGED_IN.
  - logout presses outside LOGGED_IN.
  - If load and logout are pressed in the same LOGGED_IN cycle, logout wins and load is ignored.
- Reset mid-entry or mid-lockout returns immediately to the reset values.

Optional Feature:
BCD_CRED_TIMEOUT_EN
- Defined: in ID_ENTRY or PW_ENTRY with digit_cnt > 0, an idle counter clears on each press. When it reaches TIMEOUT_CYCLES, the block pulses err, clears the field and digit_cnt, and returns to ID_ENTRY. This does not count as a failed attempt.
- Not defined: there is no idle counter and partial entries persist indefinitely.

Test Plan:
- Reset low for 2 cycles then high -> logged_out = 1, logged_in = 0, digit_cnt = 0, err = 0.
- Press digits 9,9,9,9, one load pulse each -> 2 cycles after the 4th press: logged_in = 1, is_guest = 1, logged_out = 0. Then a logout pulse -> logged_out = 1 next cycle.
- ID 1,2,3,4 then password 0,1,2,3,4,5 -> logged_in = 1, user_idx = 0, is_guest = 0. The same ID with password 0,1,2,3,4,6 -> err pulse, back in ID_ENTRY.
- Three wrong IDs (5,5,5,5) -> 3 err pulses, then locked = 1 for 100 cycles. Load presses during lockout leave digit_cnt at 0; afterwards locked = 0.
- digit_in = 4'hC with a load press -> err pulses for 1 cycle, digit_cnt unchanged. Holding load low for 5 cycles with digit_in = 2 -> digit_cnt increments by 1 only.
- With BCD_CRED_TIMEOUT_EN and TIMEOUT_CYCLES = 20: enter 1,2 then idle 20 cycles -> err pulse, digit_cnt = 0, fail_cnt unchanged.
